seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 60 ++++++
 rtl/seg7_glyph_decode.sv | 42 ++++
 rtl/seg7_scan_decoder.sv | 172 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared 7-segment definitions for the encoder and the scan decoder.
// Segment patterns are packed {a,b,c,d,e,f,g}, so segment a is bit 6 and g is bit 0.
// The alternate glyphs are listed here unconditionally. Whether the decoder accepts
// them is controlled by SEG7_ALT_GLYPH_EN inside seg7_glyph_decode.
`timescale 1ns/1ps

package seg7_pkg;

    typedef logic [6:0] seg_pattern_t;
    typedef logic [3:0] bcd_t;

    // Bit positions inside a segment pattern.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Canonical glyphs, as produced by the encoder side.
    localparam seg_pattern_t GLYPH_0 = 7'h7E;
    localparam seg_pattern_t GLYPH_1 = 7'h30;
    localparam seg_pattern_t GLYPH_2 = 7'h6D;
    localparam seg_pattern_t GLYPH_3 = 7'h79;
    localparam seg_pattern_t GLYPH_4 = 7'h33;
    localparam seg_pattern_t GLYPH_5 = 7'h5B;
    localparam seg_pattern_t GLYPH_6 = 7'h5F;
    localparam seg_pattern_t GLYPH_7 = 7'h70;
    localparam seg_pattern_t GLYPH_8 = 7'h7F;
    localparam seg_pattern_t GLYPH_9 = 7'h7B;

    // Alternate glyphs used by some third-party display drivers.
    localparam seg_pattern_t GLYPH_6_ALT = 7'h1F;   // 6 without the top bar
    localparam seg_pattern_t GLYPH_9_ALT = 7'h73;   // 9 without the bottom bar
    localparam seg_pattern_t GLYPH_7_ALT = 7'h72;   // 7 with segment f lit

    // This nibble marks a digit whose pattern could not be decoded.
    localparam bcd_t BCD_INVALID = 4'hF;

    // Encoder-side helper: BCD digit to canonical glyph. Non-BCD values blank the digit.
    function automatic seg_pattern_t bcd_to_glyph(input bcd_t bcd);
        seg_pattern_t pat;
        case (bcd)
            4'd0:    pat = GLYPH_0;
            4'd1:    pat = GLYPH_1;
            4'd2:    pat = GLYPH_2;
            4'd3:    pat = GLYPH_3;
            4'd4:    pat = GLYPH_4;
            4'd5:    pat = GLYPH_5;
            4'd6:    pat = GLYPH_6;
            4'd7:    pat = GLYPH_7;
            4'd8:    pat = GLYPH_8;
            4'd9:    pat = GLYPH_9;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode -- combinational 7-segment pattern to BCD digit decoder.
// Only exact matches are accepted. Any other pattern returns BCD_INVALID.
// Configuration macro: SEG7_ALT_GLYPH_EN. When it is defined, the tail-less 6,
// the tail-less 9 and the 7 with segment f also decode. When it is undefined,
// these three patterns return BCD_INVALID.
`timescale 1ns/1ps

module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o
);

    // Exact-match lookup of the lit-segment pattern.
    always_comb begin
        bcd_o = BCD_INVALID;
        case (seg_i)
            GLYPH_0: bcd_o = 4'd0;
            GLYPH_1: bcd_o = 4'd1;
            GLYPH_2: bcd_o = 4'd2;
            GLYPH_3: bcd_o = 4'd3;
            GLYPH_4: bcd_o = 4'd4;
            GLYPH_5: bcd_o = 4'd5;
            GLYPH_6: bcd_o = 4'd6;
            GLYPH_7: bcd_o = 4'd7;
            GLYPH_8: bcd_o = 4'd8;
            GLYPH_9: bcd_o = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
            GLYPH_6_ALT: bcd_o = 4'd6;
            GLYPH_9_ALT: bcd_o = 4'd9;
            GLYPH_7_ALT: bcd_o = 4'd7;
`else
            // The alternate glyphs are listed explicitly so they visibly decode
            // as invalid and are reported through frame_err.
            GLYPH_6_ALT, GLYPH_9_ALT, GLYPH_7_ALT: bcd_o = BCD_INVALID;
`endif
            default: bcd_o = BCD_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder -- recovers BCD digits from a time-multiplexed 7-segment bus.
// A digit is accepted once its {pattern, enable} has been stable for STABLE_CYCLES
// consecutive samples. This suppresses ghosting while the scan changes digits.
// Accepted digits collect in a shadow frame. The cycle after every digit has been
// captured, the shadow frame is published with a one-cycle frame_valid pulse.
// Configuration macro: SEG7_ALT_GLYPH_EN (applied inside seg7_glyph_decode).
`timescale 1ns/1ps

module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    mux_err
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0]      STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] EN_ONE     = NUM_DIGITS'(1);

    // Previous sample of the bus.
    logic [6:0]              prev_seg_q;
    logic [NUM_DIGITS-1:0]   prev_en_q;

    // Dwell tracking.
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;

    // Frame assembly.
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   nib_bad;

    // Published outputs.
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    mux_err_q, mux_err_d;

    // Per-sample classification.
    logic                    en_any;
    logic                    en_onehot;
    logic                    en_multi;
    logic                    qualified;
    logic                    capture;
    logic                    publish;
    bcd_t                    dec_bcd;

    // Decode the live pattern. The result is only used on a capture cycle.
    seg7_glyph_decode u_glyph_decode (
        .seg_i (seg_in),
        .bcd_o (dec_bcd)
    );

    // Classify the current bus sample. A value is one-hot when it is non-zero
    // and clearing its lowest set bit leaves zero.
    always_comb begin
        en_any    = (dig_en != '0);
        en_onehot = en_any && ((dig_en & (dig_en - EN_ONE)) == '0);
        en_multi  = en_any && !en_onehot;
        qualified = en_onehot && (seg_in == prev_seg_q) && (dig_en == prev_en_q);
    end

    // Stability counter and the capture-once-per-dwell flag. A non-qualified
    // one-hot sample starts a new dwell with the counter at 1. With
    // STABLE_CYCLES=1, that first sample is already a capture.
    always_comb begin
        cnt_d = '0;
        if (qualified) begin
            if (cnt_q >= STABLE_CNT) begin
                cnt_d = STABLE_CNT;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (en_onehot) begin
            cnt_d = CNT_ONE;
        end

        capture = en_onehot && (cnt_d == STABLE_CNT) && !(qualified && done_q);

        if (qualified) begin
            done_d = done_q | capture;
        end else begin
            done_d = capture;
        end
    end

    // A frame is published one cycle after the mask goes all-ones, so the
    // publish decision depends only on registered state.
    assign publish = &mask_q;

    // Per-digit shadow nibble, mask bit and invalid-nibble flag. A capture
    // coinciding with a publish lands after the snapshot, so its mask bit
    // survives into the next frame.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic hit;
            assign hit                   = capture && dig_en[gi];
            assign shadow_d[4*gi +: 4]   = hit ? dec_bcd : shadow_q[4*gi +: 4];
            assign mask_d[gi]            = hit | (mask_q[gi] & ~publish);
            assign nib_bad[gi]           = (shadow_q[4*gi +: 4] == BCD_INVALID);
        end
    endgenerate

    // Output next-state logic. bcd_out and frame_err hold between publishes.
    always_comb begin
        bcd_d         = bcd_q;
        frame_err_d   = frame_err_q;
        frame_valid_d = publish;
        if (publish) begin
            bcd_d       = shadow_q;
            frame_err_d = |nib_bad;
        end
        mux_err_d = mux_err_q | en_multi;
    end

    // Bus sampling and dwell-tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg_q <= '0;
            prev_en_q  <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            prev_seg_q <= seg_in;
            prev_en_q  <= dig_en;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    // Frame assembly registers. Reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '0;
            shadow_q <= '0;
        end else begin
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
        end
    end

    // Published frame and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            mux_err_q     <= 1'b0;
        end else begin
            bcd_q         <= bcd_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            mux_err_q     <= mux_err_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign mux_err     = mux_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder -- directed test of seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=3).
// Inputs are driven on the falling edge. Outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_seg7_scan_decoder;

    localparam int ND = 4;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [6:0]    seg_in = '0;
    logic [ND-1:0] dig_en = '0;
    logic [4*ND-1:0] bcd_out;
    logic          frame_valid;
    logic          frame_err;
    logic          mux_err;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            fv_count = 0;
    logic [15:0]   fv_bcd   = '0;
    logic          fv_err   = 1'b0;
    logic [15:0]   exp_alt_bcd;
    logic          exp_alt_err;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .mux_err     (mux_err)
    );

    always #5 clk = ~clk;

    // Record every frame_valid pulse together with the published frame.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count = fv_count + 1;
            fv_bcd   = bcd_out;
            fv_err   = frame_err;
        end
    end

    // Stop the run if it is still going long after the last test should have finished.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end else begin
            n_pass++;
            $display("pass %s: %0h", tag, obs);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [ND-1:0] e, input int n);
        repeat (n) begin
            @(negedge clk);
            seg_in = s;
            dig_en = e;
        end
    endtask

    task automatic idle(input int n);
        drive(7'h00, 4'b0000, n);
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input int hold);
        drive(s0, 4'b0001, hold);
        drive(s1, 4'b0010, hold);
        drive(s2, 4'b0100, hold);
        drive(s3, 4'b1000, hold);
    endtask

    initial begin
`ifdef SEG7_ALT_GLYPH_EN
        exp_alt_bcd = 16'h4621;
        exp_alt_err = 1'b0;
`else
        exp_alt_bcd = 16'h4F21;
        exp_alt_err = 1'b1;
`endif

        // Reset with an idle bus.
        repeat (3) @(negedge clk);
        check("rst_bcd_out", 32'(bcd_out), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_mux_err", 32'(mux_err), 32'h0);
        rst_n = 1'b1;
        idle(100);
        check("idle_no_frame", 32'(fv_count), 32'd0);

        // Basic scan 1,2,3,4, three samples per digit, with exact publish latency.
        fv_count = 0;
        scan4(7'h30, 7'h6D, 7'h79, 7'h33, 3);
        @(negedge clk);
        check("fv_not_early", 32'(frame_valid), 32'h0);
        @(negedge clk);
        check("fv_pulse", 32'(frame_valid), 32'h1);
        check("scan_bcd", 32'(bcd_out), 32'h4321);
        check("scan_err", 32'(frame_err), 32'h0);
        @(negedge clk);
        check("fv_one_cycle", 32'(frame_valid), 32'h0);
        idle(5);
        check("scan_frame_count", 32'(fv_count), 32'd1);

        // Two-sample dwells are too short to capture, three-sample dwells capture.
        idle(3);
        fv_count = 0;
        scan4(7'h30, 7'h6D, 7'h79, 7'h33, 2);
        idle(6);
        check("short_no_frame", 32'(fv_count), 32'd0);
        scan4(7'h30, 7'h6D, 7'h79, 7'h33, 3);
        idle(5);
        check("hold3_frame_count", 32'(fv_count), 32'd1);
        check("hold3_bcd", 32'(fv_bcd), 32'h4321);

        // Alternate glyph 6 without its tail on digit 2.
        fv_count = 0;
        scan4(7'h30, 7'h6D, 7'h1F, 7'h33, 3);
        idle(5);
        check("alt_frame_count", 32'(fv_count), 32'd1);
        check("alt_bcd", 32'(fv_bcd), 32'(exp_alt_bcd));
        check("alt_err", 32'(fv_err), 32'(exp_alt_err));

        // A one-cycle multi-hot glitch mid-scan sets mux_err. The frame still completes.
        fv_count = 0;
        check("mux_err_clear", 32'(mux_err), 32'h0);
        drive(7'h30, 4'b0001, 3);
        drive(7'h6D, 4'b0010, 3);
        drive(7'h7F, 4'b0011, 1);
        drive(7'h79, 4'b0100, 3);
        drive(7'h33, 4'b1000, 3);
        idle(5);
        check("mux_err_set", 32'(mux_err), 32'h1);
        check("mux_frame_count", 32'(fv_count), 32'd1);
        check("mux_bcd", 32'(fv_bcd), 32'h4321);
        check("mux_frame_err", 32'(fv_err), 32'h0);
        idle(20);
        check("mux_err_sticky", 32'(mux_err), 32'h1);

        // Reset after two captured digits discards the partial frame.
        drive(7'h5B, 4'b0001, 3);
        drive(7'h5F, 4'b0010, 3);
        @(negedge clk);
        rst_n  = 1'b0;
        seg_in = 7'h00;
        dig_en = 4'b0000;
        #1;
        check("async_rst_bcd", 32'(bcd_out), 32'h0);
        check("async_rst_mux_err", 32'(mux_err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        fv_count = 0;
        scan4(7'h5B, 7'h5F, 7'h70, 7'h7F, 3);
        idle(5);
        check("post_rst_frame_count", 32'(fv_count), 32'd1);
        check("post_rst_bcd", 32'(fv_bcd), 32'h8765);
        check("post_rst_err", 32'(fv_err), 32'h0);

        // Recapturing a digit before the frame completes keeps the latest value.
        fv_count = 0;
        drive(7'h30, 4'b0001, 3);
        drive(7'h7B, 4'b0001, 3);
        drive(7'h70, 4'b0010, 3);
        drive(7'h7E, 4'b0100, 3);
        drive(7'h7F, 4'b1000, 3);
        idle(5);
        check("recap_frame_count", 32'(fv_count), 32'd1);
        check("recap_bcd", 32'(fv_bcd), 32'h8079);
        check("recap_err", 32'(fv_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
